// File: rtl/dcache_controller.sv
// Dcache sequencing FSM: arbitrates one load and one store port onto the shared cache path,
// serves hits in one cycle and runs a single outstanding miss (writeback, fill, allocate).
module dcache_controller #(
  parameter int MEM_TAG_W = 4,
  parameter bit ST_FIRST  = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ld_req,
  input  logic [63:0]          ld_addr,
  output logic                 ld_done,
  output logic [63:0]          ld_data,
  input  logic                 st_req,
  input  logic [63:0]          st_addr,
  input  logic [63:0]          st_data,
  output logic                 st_done,
  output logic [63:0]          rd1_addr,
  output logic                 rd1_search,
  input  logic                 rd1_hit,
  input  logic [63:0]          rd1_data,
  output logic [63:0]          wr1_addr,
  output logic                 wr1_search,
  output logic                 wr1_en,
  output logic                 wr1_from_mem,
  output logic [63:0]          wr1_data,
  output logic                 wr1_dirty,
  output logic                 wr1_valid,
  input  logic                 wr1_hit,
  input  logic                 evicted_valid,
  input  logic                 evicted_dirty,
  input  logic [63:0]          evicted_addr,
  input  logic [63:0]          evicted_data,
  output logic [1:0]           proc2mem_command,
  output logic [63:0]          proc2mem_addr,
  output logic [63:0]          proc2mem_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  input  logic [63:0]          mem2proc_data
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_STORE = 2'b10;

  typedef enum logic [2:0] {IDLE, WB, FILL_REQ, FILL_WAIT, ALLOC} state_t;

  state_t                 state;
  logic                   rr;
  logic                   miss_st;
  logic [63:0]            miss_addr;
  logic [63:0]            miss_data;
  logic [63:0]            vic_addr;
  logic [63:0]            vic_data;
  logic [63:0]            fill_data;
  logic [MEM_TAG_W-1:0]   mem_tag;

  // A port whose done pulse is showing this cycle is still holding req; it must not be re-granted.
  logic        ld_pend, st_pend, arb_valid, grant_st, grant_ld, store_hit, tag_match;
  logic [63:0] sel_addr;

  assign ld_pend   = ld_req & ~ld_done;
  assign st_pend   = st_req & ~st_done;
  assign grant_st  = st_pend & (~ld_pend | rr);
  assign grant_ld  = ld_pend & ~grant_st;
  assign arb_valid = (state == IDLE) & ~reset & (ld_pend | st_pend);
  assign sel_addr  = grant_st ? st_addr : ld_addr;
  assign store_hit = arb_valid & grant_st & wr1_hit;
  assign tag_match = (mem_tag != '0) && (mem2proc_tag == mem_tag);

  // Cache and bus drive; the lookup must see the winner's address in the arbitration cycle itself.
  always_comb begin
    rd1_addr         = 64'd0;
    rd1_search       = 1'b0;
    wr1_addr         = 64'd0;
    wr1_search       = 1'b0;
    wr1_en           = 1'b0;
    wr1_from_mem     = 1'b0;
    wr1_data         = 64'd0;
    wr1_dirty        = 1'b0;
    wr1_valid        = 1'b0;
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = 64'd0;
    proc2mem_data    = 64'd0;
    case (state)
      IDLE: begin
        rd1_search = arb_valid;
        wr1_search = arb_valid;
        rd1_addr   = arb_valid ? sel_addr : 64'd0;
        wr1_addr   = arb_valid ? sel_addr : 64'd0;
        wr1_en     = store_hit;
        wr1_dirty  = store_hit;
        wr1_valid  = store_hit;
        wr1_data   = store_hit ? st_data : 64'd0;
      end
      WB: begin
        proc2mem_command = CMD_STORE;
        proc2mem_addr    = vic_addr;
        proc2mem_data    = vic_data;
      end
      FILL_REQ: begin
        proc2mem_command = CMD_LOAD;
        proc2mem_addr    = {miss_addr[63:3], 3'b000};
      end
      FILL_WAIT: begin
        proc2mem_command = CMD_NONE;
      end
      ALLOC: begin
        wr1_addr     = miss_addr;
        wr1_en       = 1'b1;
        wr1_from_mem = 1'b1;
        wr1_valid    = 1'b1;
        wr1_dirty    = miss_st;
        wr1_data     = miss_st ? miss_data : fill_data;
      end
      default: begin
        proc2mem_command = CMD_NONE;
      end
    endcase
  end

  // Sequencing FSM with registered done pulses and miss bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr        <= ST_FIRST;
      ld_done   <= 1'b0;
      st_done   <= 1'b0;
      ld_data   <= 64'd0;
      miss_st   <= 1'b0;
      miss_addr <= 64'd0;
      miss_data <= 64'd0;
      vic_addr  <= 64'd0;
      vic_data  <= 64'd0;
      fill_data <= 64'd0;
      mem_tag   <= '0;
    end else begin
      ld_done <= 1'b0;
      st_done <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            rr <= grant_ld;
            if (grant_ld && rd1_hit) begin
              ld_data <= rd1_data;
              ld_done <= 1'b1;
            end else if (store_hit) begin
              st_done <= 1'b1;
            end else begin
              miss_st   <= grant_st;
              miss_addr <= sel_addr;
              miss_data <= st_data;
              vic_addr  <= evicted_addr;
              vic_data  <= evicted_data;
              if (evicted_valid && evicted_dirty) state <= WB;
              else if (grant_st)                  state <= ALLOC;
              else                                state <= FILL_REQ;
            end
          end
        end
        WB: begin
          if (mem2proc_response != '0) state <= miss_st ? ALLOC : FILL_REQ;
        end
        FILL_REQ: begin
          if (mem2proc_response != '0) begin
            mem_tag <= mem2proc_response;
            state   <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (tag_match) begin
            fill_data <= mem2proc_data;
            mem_tag   <= '0;
            state     <= ALLOC;
          end
        end
        ALLOC: begin
          if (miss_st) begin
            st_done <= 1'b1;
          end else begin
            ld_done <= 1'b1;
            ld_data <= fill_data;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
